// File: rtl/spi_slave_responder.sv
// Mode-0 SPI slave (MSB first, active-high select) oversampled on the local clock.
// Optional frame_err_o output is enabled by defining SPI_FRAME_ERR_EN.
module spi_slave_responder #(
    parameter int                DATA_W      = 8,
    parameter int                SYNC_STAGES = 2,
    parameter logic [DATA_W-1:0] IDLE_FILL   = '0
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              sclk_i,
    input  logic              ss_i,
    input  logic              mosi_i,
    output logic              miso_o,
    output logic              miso_oe_o,
    input  logic [DATA_W-1:0] tx_data_i,
    input  logic              tx_valid_i,
    output logic              tx_ready_o,
    output logic [DATA_W-1:0] rx_data_o,
    output logic              rx_valid_o,
    output logic              busy_o
`ifdef SPI_FRAME_ERR_EN
    ,
    output logic              frame_err_o
`endif
);

    localparam int CNT_W = (DATA_W > 2) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

    typedef enum logic {S_IDLE, S_ACTIVE} state_t;

    logic [SYNC_STAGES-1:0] sclk_sync_q, ss_sync_q, mosi_sync_q;
    logic                   sclk_prev_q, ss_prev_q;
    state_t                 state_q, state_d;
    logic [DATA_W-1:0]      tx_shift_q, tx_shift_d;
    logic [DATA_W-1:0]      rx_shift_q, rx_shift_d;
    logic [DATA_W-1:0]      rx_data_q, rx_data_d;
    logic [DATA_W-1:0]      buf_q, buf_d;
    logic [CNT_W-1:0]       bit_cnt_q, bit_cnt_d;
    logic                   buf_full_q, buf_full_d;
    logic                   word_done_q, word_done_d;
    logic                   miso_oe_q, miso_oe_d;
    logic                   rx_valid_q, rx_valid_d;
    logic                   sclk_s, ss_s, mosi_s;
    logic                   sclk_rise, sclk_fall, ss_rise, ss_fall;
    logic                   load, capture;
`ifdef SPI_FRAME_ERR_EN
    logic                   frame_err_q, frame_err_d;
`endif

    assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
    assign ss_s      = ss_sync_q[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_prev_q;
    assign sclk_fall = ~sclk_s & sclk_prev_q;
    assign ss_rise   = ss_s & ~ss_prev_q;
    assign ss_fall   = ~ss_s & ss_prev_q;
    assign capture   = tx_valid_i & ~buf_full_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sclk_sync_q <= '0;
            ss_sync_q   <= '0;
            mosi_sync_q <= '0;
            sclk_prev_q <= 1'b0;
            ss_prev_q   <= 1'b0;
            state_q     <= S_IDLE;
            tx_shift_q  <= '0;
            rx_shift_q  <= '0;
            rx_data_q   <= '0;
            buf_q       <= '0;
            bit_cnt_q   <= '0;
            buf_full_q  <= 1'b0;
            word_done_q <= 1'b0;
            miso_oe_q   <= 1'b0;
            rx_valid_q  <= 1'b0;
`ifdef SPI_FRAME_ERR_EN
            frame_err_q <= 1'b0;
`endif
        end else begin
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk_i};
            ss_sync_q   <= {ss_sync_q[SYNC_STAGES-2:0], ss_i};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi_i};
            sclk_prev_q <= sclk_s;
            ss_prev_q   <= ss_s;
            state_q     <= state_d;
            tx_shift_q  <= tx_shift_d;
            rx_shift_q  <= rx_shift_d;
            rx_data_q   <= rx_data_d;
            buf_q       <= buf_d;
            bit_cnt_q   <= bit_cnt_d;
            buf_full_q  <= buf_full_d;
            word_done_q <= word_done_d;
            miso_oe_q   <= miso_oe_d;
            rx_valid_q  <= rx_valid_d;
`ifdef SPI_FRAME_ERR_EN
            frame_err_q <= frame_err_d;
`endif
        end
    end

    always_comb begin
        state_d     = state_q;
        tx_shift_d  = tx_shift_q;
        rx_shift_d  = rx_shift_q;
        rx_data_d   = rx_data_q;
        bit_cnt_d   = bit_cnt_q;
        word_done_d = word_done_q;
        miso_oe_d   = miso_oe_q;
        rx_valid_d  = 1'b0;
        load        = 1'b0;
`ifdef SPI_FRAME_ERR_EN
        frame_err_d = 1'b0;
`endif
        // Deselect overrides everything, including an sclk edge seen in the same cycle.
        if (ss_fall) begin
            state_d     = S_IDLE;
            miso_oe_d   = 1'b0;
            rx_shift_d  = '0;
            bit_cnt_d   = '0;
            word_done_d = 1'b0;
`ifdef SPI_FRAME_ERR_EN
            frame_err_d = (bit_cnt_q != '0);
`endif
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (ss_rise) begin
                        state_d     = S_ACTIVE;
                        load        = 1'b1;
                        bit_cnt_d   = '0;
                        rx_shift_d  = '0;
                        word_done_d = 1'b0;
                        miso_oe_d   = 1'b1;
                    end
                end
                S_ACTIVE: begin
                    if (sclk_rise) begin
                        rx_shift_d = {rx_shift_q[DATA_W-2:0], mosi_s};
                        if (bit_cnt_q == LAST_BIT) begin
                            rx_data_d   = {rx_shift_q[DATA_W-2:0], mosi_s};
                            rx_valid_d  = 1'b1;
                            bit_cnt_d   = '0;
                            word_done_d = 1'b1;
                        end else begin
                            bit_cnt_d = bit_cnt_q + CNT_W'(1);
                        end
                    end else if (sclk_fall) begin
                        if (word_done_q) begin
                            load        = 1'b1;
                            word_done_d = 1'b0;
                        end else begin
                            tx_shift_d = tx_shift_q << 1;
                        end
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end

        // A load sees the buffer as it was at the start of the cycle; a same-cycle capture refills it.
        if (load) begin
            tx_shift_d = buf_full_q ? buf_q : IDLE_FILL;
`ifdef SPI_FRAME_ERR_EN
            frame_err_d = ~buf_full_q;
`endif
        end
        buf_d      = capture ? tx_data_i : buf_q;
        buf_full_d = capture ? 1'b1 : (load ? 1'b0 : buf_full_q);
    end

    assign miso_o     = miso_oe_q & tx_shift_q[DATA_W-1];
    assign miso_oe_o  = miso_oe_q;
    assign tx_ready_o = ~buf_full_q;
    assign rx_data_o  = rx_data_q;
    assign rx_valid_o = rx_valid_q;
    assign busy_o     = (state_q == S_ACTIVE);
`ifdef SPI_FRAME_ERR_EN
    assign frame_err_o = frame_err_q;
`endif

endmodule

// File: tb/tb_spi_slave_responder.sv
// Directed + random bench for spi_slave_responder: scoreboard queues for RX words and MISO words.
module tb_spi_slave_responder;

    logic       clk = 1'b0, rst = 1'b1;
    logic       sclk = 1'b0, ss = 1'b0, mosi = 1'b0;
    logic       miso, miso_oe, tx_ready, rx_valid, busy;
    logic       tx_valid = 1'b0;
    logic [7:0] tx_data = 8'h00, rx_data;
`ifdef SPI_FRAME_ERR_EN
    logic       frame_err;
    int         ferr_cnt = 0;
`endif

    int         chk_cnt = 0, pass_cnt = 0, fail_cnt = 0;
    int         rx_pulses = 0;
    logic       rx_valid_prev = 1'b0;
    logic [7:0] rx_exp_q[$];
    logic [7:0] miso_exp_q[$];

    always #5 clk = ~clk;

    spi_slave_responder #(.DATA_W(8), .SYNC_STAGES(2), .IDLE_FILL(8'h00)) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .sclk_i     (sclk),
        .ss_i       (ss),
        .mosi_i     (mosi),
        .miso_o     (miso),
        .miso_oe_o  (miso_oe),
        .tx_data_i  (tx_data),
        .tx_valid_i (tx_valid),
        .tx_ready_o (tx_ready),
        .rx_data_o  (rx_data),
        .rx_valid_o (rx_valid),
        .busy_o     (busy)
`ifdef SPI_FRAME_ERR_EN
        ,
        .frame_err_o(frame_err)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // RX scoreboard: every rx_valid pulse pops the next expected word.
    always @(negedge clk) begin
        if (rx_valid) begin
            rx_pulses++;
            if (rx_valid_prev) check("rx_valid_one_clk", rx_valid_prev, 1'b0);
            if (rx_exp_q.size() == 0) check("rx_unexpected", rx_valid, 1'b0);
            else check("rx_data", rx_data, rx_exp_q.pop_front());
            $display("rx word %02h", rx_data);
        end
        rx_valid_prev = rx_valid;
`ifdef SPI_FRAME_ERR_EN
        if (frame_err) ferr_cnt++;
`endif
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic load_tx(input logic [7:0] d);
        int t;
        t = 0;
        while (!tx_ready && t < 64) begin
            tick(1);
            t++;
        end
        check("tx_ready_wait", tx_ready, 1'b1);
        tx_data  = d;
        tx_valid = 1'b1;
        tick(1);
        tx_valid = 1'b0;
        check("tx_ready_drop", tx_ready, 1'b0);
    endtask

    task automatic send_bit(input logic b, output logic m);
        mosi = b;
        tick(4);
        m    = miso;
        sclk = 1'b1;
        tick(4);
        sclk = 1'b0;
    endtask

    task automatic send_word(input logic [7:0] d, input logic refill_en, input logic [7:0] refill_d);
        logic [7:0] got;
        logic       m;
        got = '0;
        rx_exp_q.push_back(d);
        for (int i = 7; i >= 0; i--) begin
            send_bit(d[i], m);
            got[i] = m;
            if (refill_en && i == 4) load_tx(refill_d);
        end
        if (miso_exp_q.size() == 0) check("miso_expect_missing", miso_exp_q.size(), 1);
        else check("miso_word", got, miso_exp_q.pop_front());
        $display("word mosi %02h miso %02h", d, got);
    endtask

    task automatic ss_begin();
        ss = 1'b1;
        tick(8);
    endtask

    task automatic ss_end();
        ss = 1'b0;
        tick(8);
    endtask

    initial begin
        logic       m;
        logic [7:0] r, nt;
`ifdef SPI_FRAME_ERR_EN
        int         ferr_base;
`endif

        // Reset values
        tick(3);
        check("rst_miso", miso, 1'b0);
        check("rst_miso_oe", miso_oe, 1'b0);
        check("rst_tx_ready", tx_ready, 1'b1);
        check("rst_rx_data", rx_data, 8'h00);
        check("rst_rx_valid", rx_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        rst = 1'b0;
        tick(4);

        // Preloaded word A5 while receiving 3C
        load_tx(8'hA5);
        miso_exp_q.push_back(8'hA5);
        ss_begin();
        check("t1_busy", busy, 1'b1);
        check("t1_miso_oe", miso_oe, 1'b1);
        check("t1_tx_ready_after_load", tx_ready, 1'b1);
        send_word(8'h3C, 1'b0, 8'h00);
        ss_end();
        check("t1_oe_off", miso_oe, 1'b0);
        check("t1_busy_off", busy, 1'b0);

        // No preload: idle fill shifted out
`ifdef SPI_FRAME_ERR_EN
        ferr_base = ferr_cnt;
`endif
        miso_exp_q.push_back(8'h00);
        ss_begin();
        send_word(8'hFF, 1'b0, 8'h00);
        ss_end();
`ifdef SPI_FRAME_ERR_EN
        check("t2_frame_err_underrun", (ferr_cnt > ferr_base), 1'b1);
`endif

        // Two back-to-back words with a refill during the first
        load_tx(8'h11);
        miso_exp_q.push_back(8'h11);
        miso_exp_q.push_back(8'h22);
        ss_begin();
        send_word(8'hC3, 1'b1, 8'h22);
        send_word(8'h5A, 1'b0, 8'h00);
        ss_end();

        // Abort after 5 bits: no rx_valid, rx_data held
`ifdef SPI_FRAME_ERR_EN
        ferr_base = ferr_cnt;
`endif
        ss_begin();
        for (int i = 0; i < 5; i++) send_bit(1'b1, m);
        ss_end();
        check("t4_rx_data_held", rx_data, 8'h5A);
        check("t4_oe_off", miso_oe, 1'b0);
        check("t4_busy_off", busy, 1'b0);
        check("t4_miso_low", miso, 1'b0);
`ifdef SPI_FRAME_ERR_EN
        check("t4_frame_err_abort", (ferr_cnt > ferr_base), 1'b1);
`endif
        load_tx(8'h77);
        miso_exp_q.push_back(8'h77);
        ss_begin();
        send_word(8'h96, 1'b0, 8'h00);
        ss_end();

        // Asynchronous reset mid-word, sampled before any clock edge
        ss_begin();
        for (int i = 0; i < 3; i++) send_bit(1'b0, m);
        load_tx(8'hEE);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("t5_miso", miso, 1'b0);
        check("t5_miso_oe", miso_oe, 1'b0);
        check("t5_tx_ready", tx_ready, 1'b1);
        check("t5_rx_data", rx_data, 8'h00);
        check("t5_rx_valid", rx_valid, 1'b0);
        check("t5_busy", busy, 1'b0);
        ss   = 1'b0;
        sclk = 1'b0;
        mosi = 1'b0;
        tick(2);
        rst = 1'b0;
        tick(4);

        // 200 random back-to-back words in one select window
        nt = 8'($urandom);
        load_tx(nt);
        miso_exp_q.push_back(nt);
        ss_begin();
        for (int k = 0; k < 200; k++) begin
            r  = 8'($urandom);
            nt = 8'($urandom);
            if (k < 199) miso_exp_q.push_back(nt);
            send_word(r, (k < 199), nt);
        end
        ss_end();

        tick(10);
        check("rx_queue_drained", rx_exp_q.size(), 0);
        check("miso_queue_drained", miso_exp_q.size(), 0);
        check("rx_pulse_count", rx_pulses, 205);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
